// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcodes, ALU op codes, sequencer states, strobe bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int CPU_ADDR_W = 4;
    localparam int CPU_OPC_W  = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXEC      = 3'd2,
        ST_HALT      = 3'd3,
        ST_STEP_WAIT = 3'd4
    } state_e;

    // Everything the execute stage may assert in its single EXECUTE cycle.
    typedef struct packed {
        logic       acc_load_en;
        logic [1:0] alu_op;
        logic       alu_src_imm;
        logic       mem_we;
        logic       jump_en;
        logic       illegal_op;
        logic       is_hlt;
    } strobe_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode + flag decode into the execute strobe bundle.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the strobes are used.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int OPC_W = CPU_OPC_W
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero_flag,
    input  logic             carry_flag,
    output strobe_t          strb
);

    // Opcode table; conditional jumps look at the flags live in this cycle.
    always_comb begin
        strb = '0;
        case (opcode)
            OPC_W'(OP_NOP): ;
            OPC_W'(OP_LDA): begin strb.acc_load_en = 1'b1; strb.alu_op = ALU_PASS; end
            OPC_W'(OP_ADD): begin strb.acc_load_en = 1'b1; strb.alu_op = ALU_ADD;  end
            OPC_W'(OP_SUB): begin strb.acc_load_en = 1'b1; strb.alu_op = ALU_SUB;  end
            OPC_W'(OP_STA): strb.mem_we = 1'b1;
            OPC_W'(OP_LDI): begin
                strb.acc_load_en = 1'b1;
                strb.alu_op      = ALU_PASS;
                strb.alu_src_imm = 1'b1;
            end
            OPC_W'(OP_JMP): strb.jump_en = 1'b1;
            OPC_W'(OP_JZ):  strb.jump_en = zero_flag;
            OPC_W'(OP_JC):  strb.jump_en = carry_flag;
            OPC_W'(OP_HLT): strb.is_hlt = 1'b1;
            default:        strb.illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: IR, 3-cycle FSM, one-cycle execute strobes. Option: INSTR_SEQUENCER_SINGLE_STEP_EN.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE); HLT parks in HALTED until reset.
// Backpressure: none from downstream; halt freezes the counter (also while parked in STEP_WAIT).
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int OPC_W  = CPU_OPC_W
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    input  logic                    step_mode,
    input  logic                    step_req,
`endif
    input  logic [OPC_W+ADDR_W-1:0] instr_in,
    input  logic                    zero_flag,
    input  logic                    carry_flag,
    output logic                    ir_load_en,
    output logic                    jump_en,
    output logic [ADDR_W-1:0]       jump_addr,
    output logic                    halt,
    output logic [OPC_W+ADDR_W-1:0] ir_out,
    output logic                    acc_load_en,
    output logic [1:0]              alu_op,
    output logic                    alu_src_imm,
    output logic                    mem_we,
    output logic                    illegal_op
);

    localparam int IW = OPC_W + ADDR_W;

    state_e           state_q, state_d;
    logic [IW-1:0]    ir_q, ir_d;
    logic [OPC_W-1:0] op_q, op_d;
    strobe_t          dec;

    instr_decoder #(.OPC_W(OPC_W)) u_dec (
        .opcode     (op_q),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .strb       (dec)
    );

    // Next state, IR capture in FETCH, opcode register in DECODE.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        op_d    = op_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = instr_in;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d    = ir_q[IW-1 -: OPC_W];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec.is_hlt) begin
                    state_d = ST_HALT;
                end else begin
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
                    state_d = step_mode ? ST_STEP_WAIT : ST_FETCH;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HALT: state_d = ST_HALT;
            ST_STEP_WAIT: begin
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
                state_d = step_req ? ST_FETCH : ST_STEP_WAIT;
`else
                state_d = ST_FETCH;
`endif
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State, IR and decoded-opcode registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            op_q    <= op_d;
        end
    end

    // Strobes; forced quiet while reset is high so nothing leaks mid-instruction.
    always_comb begin
        ir_load_en  = 1'b0;
        jump_en     = 1'b0;
        halt        = 1'b0;
        acc_load_en = 1'b0;
        alu_op      = ALU_PASS;
        alu_src_imm = 1'b0;
        mem_we      = 1'b0;
        illegal_op  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: ir_load_en = 1'b1;
                ST_EXEC: begin
                    jump_en     = dec.jump_en;
                    acc_load_en = dec.acc_load_en;
                    alu_op      = dec.alu_op;
                    alu_src_imm = dec.alu_src_imm;
                    mem_we      = dec.mem_we;
                    illegal_op  = dec.illegal_op;
                end
                ST_HALT:      halt = 1'b1;
                ST_STEP_WAIT: halt = 1'b1;
                default: ;
            endcase
        end
    end

    assign jump_addr = ir_q[ADDR_W-1:0];
    assign ir_out    = ir_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: ROM + program counter around the sequencer, instruction-level reference model.
// Latency: model expects 3 cycles per instruction and a parked HALTED state after HLT.
// Backpressure: the bench counter obeys ir_load_en / jump_en / halt from the DUT.
module tb_instr_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] instr_in;
    logic       zero_flag, carry_flag;
    logic       ir_load_en, jump_en, halt;
    logic [3:0] jump_addr;
    logic [7:0] ir_out;
    logic       acc_load_en;
    logic [1:0] alu_op;
    logic       alu_src_imm, mem_we, illegal_op;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
    logic       step_mode, step_req;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rom [16];
    logic [3:0] pc;

    // reference model state: next fetch address, expected IR, halted flag
    logic [3:0] mpc;
    logic [7:0] mir;
    logic       mhalt;

    instr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        .step_mode   (step_mode),
        .step_req    (step_req),
`endif
        .instr_in    (instr_in),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .ir_load_en  (ir_load_en),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .ir_out      (ir_out),
        .acc_load_en (acc_load_en),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .mem_we      (mem_we),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // program counter: load wins, increment on fetch, frozen by halt
    always @(posedge clk) begin
        if (reset)                        pc <= 4'h0;
        else if (jump_en)                 pc <= jump_addr;
        else if (ir_load_en && !halt)     pc <= pc + 4'h1;
    end

    assign instr_in = rom[pc];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // expected execute strobes {acc_load_en, alu_op, alu_src_imm, mem_we, jump_en, illegal_op}
    function automatic logic [6:0] exp_exec(input logic [3:0] op, input logic z, input logic c);
        case (op)
            4'h0:    return 7'b0_00_0_0_0_0;
            4'h1:    return 7'b1_00_0_0_0_0;
            4'h2:    return 7'b1_01_0_0_0_0;
            4'h3:    return 7'b1_10_0_0_0_0;
            4'h4:    return 7'b0_00_0_1_0_0;
            4'h5:    return 7'b1_00_1_0_0_0;
            4'h6:    return 7'b0_00_0_0_1_0;
            4'h7:    return {6'b0_00_0_0_0, 1'b0} | {5'b0, z, 1'b0};
            4'h8:    return {5'b0, c, 1'b0};
            4'hF:    return 7'b0;
            default: return 7'b0_00_0_0_0_1;
        endcase
    endfunction

    task automatic rand_flags();
        zero_flag  = 1'($urandom);
        carry_flag = 1'($urandom);
    endtask

    // one clock: check at negedge, return one step after the next posedge
    task automatic cycle(input string tag, input logic ild, input logic hlt,
                         input logic [6:0] strb, input logic [7:0] ir);
        @(negedge clk);
        chk({tag, ".ir_load_en"}, 32'(ir_load_en), 32'(ild));
        chk({tag, ".halt"}, 32'(halt), 32'(hlt));
        chk({tag, ".strobes"},
            32'({acc_load_en, alu_op, alu_src_imm, mem_we, jump_en, illegal_op}), 32'(strb));
        chk({tag, ".ir_out"}, 32'(ir_out), 32'(ir));
        chk({tag, ".jump_addr"}, 32'(jump_addr), 32'(ir[3:0]));
        chk({tag, ".no_overlap"}, 32'(ir_load_en & jump_en), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rand_flags();
        @(negedge clk);
        chk("rst.strobes", 32'({ir_load_en, jump_en, halt, acc_load_en, alu_op,
                                alu_src_imm, mem_we, illegal_op}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mpc   = 4'h0;
        mir   = 8'h00;
        mhalt = 1'b0;
    endtask

    // zf/cf: -1 randomises the flag in EXECUTE, otherwise forces it
    task automatic run_instr(input int zf = -1, input int cf = -1);
        logic [7:0] w;
        logic [6:0] e;
        w = rom[mpc];
        chk("fetch.pc", 32'(pc), 32'(mpc));
        rand_flags();
        cycle("fetch", 1'b1, 1'b0, 7'd0, mir);
        mpc = mpc + 4'h1;
        mir = w;
        rand_flags();
        cycle("decode", 1'b0, 1'b0, 7'd0, w);
        rand_flags();
        if (zf >= 0) zero_flag  = zf[0];
        if (cf >= 0) carry_flag = cf[0];
        e = exp_exec(w[7:4], zero_flag, carry_flag);
        cycle("exec", 1'b0, 1'b0, e, w);
        if (e[1]) mpc = w[3:0];
        if (w[7:4] == 4'hF) mhalt = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        zero_flag  = 1'b0;
        carry_flag = 1'b0;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        step_mode  = 1'b0;
        step_req   = 1'b0;
`endif
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        @(posedge clk);
        #1;

        // directed program: LDI, JMP, JZ untaken, JZ taken, illegal, HLT
        rom[0]  = 8'h53;
        rom[1]  = 8'h6A;
        rom[10] = 8'h74;
        rom[11] = 8'h74;
        rom[4]  = 8'hB0;
        rom[5]  = 8'hF0;
        do_reset();
        run_instr();
        run_instr();
        run_instr(0, -1);
        chk("jz_untaken.mpc", 32'(mpc), 32'hB);
        run_instr(1, -1);
        chk("jz_taken.mpc", 32'(mpc), 32'h4);
        run_instr();
        run_instr();
        for (int i = 0; i < 22; i++) begin
            rand_flags();
            cycle("halted", 1'b0, 1'b1, 7'd0, mir);
        end
        chk("halted.pc", 32'(pc), 32'h6);
        do_reset();
        run_instr();

        // reset during DECODE of STA: no mem_we, restart in FETCH
        rom[0] = 8'h45;
        do_reset();
        rand_flags();
        cycle("sta.fetch", 1'b1, 1'b0, 7'd0, 8'h00);
        reset = 1'b1;
        cycle("sta.rst_decode", 1'b0, 1'b0, 7'd0, 8'h45);
        reset  = 1'b0;
        mpc    = 4'h0;
        mir    = 8'h00;
        mhalt  = 1'b0;
        rom[0] = 8'h00;
        run_instr();

        // random programs
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            do_reset();
            for (int n = 0; n < 30 && !mhalt; n++) run_instr();
            if (mhalt) begin
                for (int i = 0; i < 3; i++) begin
                    rand_flags();
                    cycle("r_halted", 1'b0, 1'b1, 7'd0, mir);
                end
            end
        end

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        for (int i = 0; i < 16; i++) rom[i] = 8'h50 | 8'(i);
        rom[3] = 8'hF0;
        do_reset();
        step_mode = 1'b1;
        run_instr();
        for (int i = 0; i < 4; i++) cycle("step_wait", 1'b0, 1'b1, 7'd0, mir);
        step_req = 1'b1;
        cycle("step_req", 1'b0, 1'b1, 7'd0, mir);
        step_req = 1'b0;
        run_instr();
        for (int i = 0; i < 3; i++) cycle("step_wait2", 1'b0, 1'b1, 7'd0, mir);
        chk("step.pc", 32'(pc), 32'h2);
        step_req = 1'b1;
        cycle("step_req2", 1'b0, 1'b1, 7'd0, mir);
        step_req = 1'b0;
        run_instr();
        step_req = 1'b1;
        cycle("step_req3", 1'b0, 1'b1, 7'd0, mir);
        step_req = 1'b0;
        run_instr();
        // HLT under step mode goes to HALTED; step_req cannot leave it
        step_req = 1'b1;
        cycle("step_halt", 1'b0, 1'b1, 7'd0, mir);
        step_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle("step_halt2", 1'b0, 1'b1, 7'd0, mir);
        step_mode = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/execute control stage directly downstream of the program counter.
- Latches the instruction ROM word addressed by pc_out into the instruction register (IR).
- Decodes the IR and drives the counter's ir_load_en, jump_en, jump_addr and halt.
- Issues one-cycle datapath strobes (accumulator, ALU, RAM) to the execute stage.

Parameters:
- ADDR_W, 4, PC/operand address width; jump_addr and operand width.
- OPC_W, 4, opcode width; instruction word is OPC_W+ADDR_W bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  OPC_W+ADDR_W  ROM data at the current pc_out; valid combinationally in the FETCH cycle.
- zero_flag  in  1  accumulator-zero flag from the ALU.
- carry_flag  in  1  carry flag from the ALU.
- ir_load_en  out  1  IR load, and PC increment enable to the counter.
- jump_en  out  1  PC load strobe to the counter.
- jump_addr  out  ADDR_W  PC load value; equals the IR operand.
- halt  out  1  freezes the counter; held while in HALTED.
- ir_out  out  OPC_W+ADDR_W  current IR contents.
- acc_load_en  out  1  accumulator load strobe.
- alu_op  out  2  00 pass, 01 add, 10 sub; other codes reserved.
- alu_src_imm  out  1  1 selects the operand as immediate; 0 selects RAM data.
- mem_we  out  1  RAM write strobe; address is the operand.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- States: FETCH -> DECODE -> EXECUTE -> FETCH. HLT goes to HALTED. Each instruction takes 3 cycles.
- Reset, in any state and mid-instruction: state=FETCH, IR=0, all strobes 0, halt=0, alu_op=00, alu_src_imm=0.
- FETCH: ir_load_en=1 for exactly one cycle. IR <= instr_in at that edge; the counter increments at the same edge.
- DECODE: all strobes 0. Internal opcode/operand decode is registered.
- EXECUTE: the decoded strobes are asserted for exactly one cycle.
- Opcodes:
  - 0 NOP: no strobes.
  - 1 LDA: acc_load_en, alu_op=00, alu_src_imm=0.
  - 2 ADD: acc_load_en, alu_op=01, alu_src_imm=0.
  - 3 SUB: acc_load_en, alu_op=10, alu_src_imm=0.
  - 4 STA: mem_we.
  - 5 LDI: acc_load_en, alu_op=00, alu_src_imm=1.
  - 6 JMP: jump_en.
  - 7 JZ: jump_en only if zero_flag=1.
  - 8 JC: jump_en only if carry_flag=1.
  - F HLT: no strobe; next state HALTED.
  - 9..E: treated as NOP; illegal_op=1 in EXECUTE.
- Flag sampling: zero_flag and carry_flag are sampled in the EXECUTE cycle.
- Jump timing: jump_addr is driven from the IR operand at all times. A taken jump loads the PC at the edge ending EXECUTE, so the next FETCH sees pc_out = target. An untaken jump falls through to PC+1, already incremented during FETCH.
- Jump to self (e.g. JMP to its own address) loops indefinitely; this is legal.
- PC wrap 0xF -> 0x0 is owned by the counter; the sequencer ignores it.
- HALTED: halt=1 and all strobes 0 on every cycle; instr_in is ignored. Only reset exits HALTED.
- Invariant: ir_load_en and jump_en are never asserted in the same cycle.

Optional Feature:
- Macro: INSTR_SEQUENCER_SINGLE_STEP_EN.
- With the macro defined:
  - Adds inputs step_mode (1 bit) and step_req (1-cycle pulse), and state STEP_WAIT.
  - When step_mode=1, EXECUTE goes to STEP_WAIT instead of FETCH. halt=1 while in STEP_WAIT.
  - A step_req pulse moves STEP_WAIT to FETCH on the next edge.
  - step_req outside STEP_WAIT is ignored. HLT still wins and goes to HALTED.
- Without the macro: no extra ports or state; behaviour is exactly as above.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_NOP..OP_HLT;
  - ALU op codes ALU_PASS/ALU_ADD/ALU_SUB;
  - state encoding ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT, ST_STEP_WAIT;
  - ADDR_W and OPC_W defaults.
- One sub-module, instr_decoder: combinational mapping from opcode plus flags to the strobe vector. The FSM and IR stay in instr_sequencer.

Test Plan:
- Reset then ROM[0]=0x5_3 (LDI 3): ir_load_en high in cycle 1 only; acc_load_en=1, alu_src_imm=1, alu_op=00 in cycle 3; ir_load_en again in cycle 4.
- ROM[1]=0x6_A (JMP 0xA): jump_en=1 with jump_addr=1010 in EXECUTE; the next FETCH latches ROM[0xA]; ir_load_en and jump_en never overlap.
- JZ 0x4 run twice, once with zero_flag=0 and once with zero_flag=1: jump_en=0 with the PC continuing sequentially, then jump_en=1 with jump_addr=0100.
- Opcode 0xB: illegal_op=1 for one cycle in EXECUTE, no other strobes, then normal fetch resumes.
- HLT (0xF0): halt=1 from the cycle after EXECUTE, held for 20+ cycles with no ir_load_en. reset=1 for one cycle restores FETCH, halt=0, IR=0.
- Reset asserted during DECODE of an STA: mem_we is never pulsed; the FSM restarts in FETCH. Under INSTR_SEQUENCER_SINGLE_STEP_EN with step_mode=1: the FSM parks in STEP_WAIT with halt=1; one step_req pulse causes exactly one further instruction.
